// File: rtl/pp_csa_accumulator.sv
// rtl/pp_csa_accumulator.sv - carry-save multi-operand accumulator with final CPA and valid/ready result
// Optional feature macro: PP_ACC_OVF_EN (adds out_ovf and guard bits on the S/C registers and CPA)
module pp_csa_accumulator #(
   parameter int WIDTH     = 32,
   parameter int MAX_TERMS = 8,
   localparam int CW       = $clog2(MAX_TERMS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_pp,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic [CW-1:0]    out_terms,
`ifdef PP_ACC_OVF_EN
   output logic             out_ovf,
`endif
   output logic             out_trunc
);

`ifdef PP_ACC_OVF_EN
   // Guard bits keep the carry-save pair exact for up to MAX_TERMS full-width terms
   localparam int GB = ($clog2(MAX_TERMS) > 0) ? $clog2(MAX_TERMS) : 1;
`else
   localparam int GB = 0;
`endif
   localparam int SW = WIDTH + GB;

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      RESOLVE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [SW-1:0] s_q;
   logic [SW-1:0] c_q;
   logic [CW-1:0] count;
   logic [CW-1:0] count_inc;
   logic [SW-1:0] pp_ext;
   logic [SW-1:0] s_nxt;
   logic [SW-1:0] c_nxt;
   logic [SW-1:0] cpa;
   logic          accept;
   logic          at_limit;

   assign pp_ext    = SW'(in_pp);
   assign count_inc = count + 1'b1;
   assign at_limit  = (count_inc == CW'(MAX_TERMS));

   // One full-adder row: sum bits stay in place, majority bits move up one position
   assign s_nxt = s_q ^ c_q ^ pp_ext;
   assign c_nxt = {(s_q[SW-2:0] & c_q[SW-2:0]) |
                   (s_q[SW-2:0] & pp_ext[SW-2:0]) |
                   (c_q[SW-2:0] & pp_ext[SW-2:0]), 1'b0};
   assign cpa   = s_q + c_q;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ACCUM;
      else        state <= state_nxt;
   end

   // Next-state and handshake outputs; no overlap between accepting terms and returning a result
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept = 1'b1;
               if (in_last || at_limit) state_nxt = RESOLVE;
            end
         end
         RESOLVE: state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ACCUM;
         end
         default: state_nxt = ACCUM;
      endcase
   end

   // Carry-save accumulation, final resolve and result hold/clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_q       <= '0;
         c_q       <= '0;
         count     <= '0;
         out_sum   <= '0;
         out_terms <= '0;
         out_trunc <= 1'b0;
`ifdef PP_ACC_OVF_EN
         out_ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  s_q   <= s_nxt;
                  c_q   <= c_nxt;
                  count <= count_inc;
                  if (at_limit && !in_last) out_trunc <= 1'b1;
               end
            end
            RESOLVE: begin
               out_sum   <= cpa[WIDTH-1:0];
               out_terms <= count;
`ifdef PP_ACC_OVF_EN
               out_ovf   <= |cpa[SW-1:WIDTH];
`endif
               s_q       <= '0;
               c_q       <= '0;
               count     <= '0;
            end
            DONE: begin
               if (out_ready) begin
                  out_trunc <= 1'b0;
`ifdef PP_ACC_OVF_EN
                  out_ovf   <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pp_csa_accumulator.sv
// tb/tb_pp_csa_accumulator.sv - self-checking bench for pp_csa_accumulator against an arithmetic sum model
module tb_pp_csa_accumulator;
   localparam int WIDTH     = 32;
   localparam int MAX_TERMS = 8;
   localparam int CW        = $clog2(MAX_TERMS + 1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_pp = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_sum;
   logic [CW-1:0]    out_terms;
   logic             out_trunc;
`ifdef PP_ACC_OVF_EN
   logic             out_ovf;
`endif

   int n_checks = 0;
   int n_errors = 0;

   pp_csa_accumulator #(.WIDTH(WIDTH), .MAX_TERMS(MAX_TERMS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pp     (in_pp),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_terms (out_terms),
`ifdef PP_ACC_OVF_EN
      .out_ovf   (out_ovf),
`endif
      .out_trunc (out_trunc)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one term after `gap` idle cycles; returns once it has been accepted
   task automatic send_term(input logic [WIDTH-1:0] pp, input bit last, input int gap);
      int budget;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         in_pp    = $urandom;
         in_last  = $urandom_range(0, 1);
         tick();
      end
      in_valid = 1'b1;
      in_pp    = pp;
      in_last  = last;
      budget   = 0;
      while (!in_ready && budget < 50) begin
         tick();
         budget++;
      end
      check("accept_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_pp    = $urandom;
   endtask

   // Wait for a result, hold off out_ready for `hold` cycles, compare, then hand it off
   task automatic get_result(input string tag, input logic [63:0] sum64, input int terms,
                             input bit trunc, input int hold);
      int budget;
      logic [WIDTH-1:0] exp_sum;
      logic             exp_ovf;
      exp_sum = sum64[WIDTH-1:0];
      exp_ovf = (sum64 >= 64'h1_0000_0000);
      budget  = 0;
      while (!out_valid && budget < 50) begin
         tick();
         budget++;
      end
      check({tag, "_valid"}, out_valid, 1);
      for (int h = 0; h < hold; h++) begin
         check({tag, "_hold_sum"}, out_sum, exp_sum);
         check({tag, "_hold_valid"}, out_valid, 1);
         check({tag, "_hold_inready"}, in_ready, 0);
         tick();
      end
      check({tag, "_sum"}, out_sum, exp_sum);
      check({tag, "_terms"}, out_terms, terms);
      check({tag, "_trunc"}, out_trunc, trunc);
`ifdef PP_ACC_OVF_EN
      check({tag, "_ovf"}, out_ovf, exp_ovf);
`else
      if (exp_ovf) n_checks += 0;
`endif
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check({tag, "_clr_valid"}, out_valid, 0);
      check({tag, "_clr_trunc"}, out_trunc, 0);
      check({tag, "_clr_inready"}, in_ready, 1);
   endtask

   initial begin
      logic [63:0] sum;
      logic [WIDTH-1:0] t;
      int n;
      bit force_close;

      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_inready", in_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_sum", out_sum, 0);
      check("rst_terms", out_terms, 0);
      check("rst_trunc", out_trunc, 0);
      rst_n = 1'b1;
      tick();

      // 1: terms 1..8, last on the 8th, with latency check
      for (int i = 1; i <= 8; i++) send_term(WIDTH'(i), i == 8, 0);
      check("t1_lat_resolve", out_valid, 0);
      tick();
      check("t1_lat_done", out_valid, 1);
      get_result("t1", 36, 8, 0, 0);

      // 4: wrap-around result held while consumer stalls; producer pushes a term meanwhile
      send_term(32'hFFFF_FFFF, 0, 0);
      send_term(32'h2, 1, 0);
      in_valid = 1'b1;
      in_pp    = 32'h0000_0055;
      in_last  = 1'b1;
      get_result("t4", 64'h1_0000_0001, 2, 0, 5);

      // 2: single term passes through unchanged
      send_term(32'hDEAD_BEEF, 1, 0);
      get_result("t2", 64'hDEAD_BEEF, 1, 0, 0);

      // 3: nine terms without last: forced close at eight, ninth opens a new transaction
      for (int i = 0; i < 8; i++) send_term(32'h1, 0, 0);
      get_result("t3a", 8, 8, 1, 1);
      send_term(32'h1, 0, 0);
      send_term(32'h1, 1, 0);
      get_result("t3b", 2, 2, 0, 0);

      // 5: reset mid-transaction leaves no residue
      send_term(32'd100, 0, 0);
      send_term(32'd200, 0, 1);
      send_term(32'd300, 0, 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t5_rst_inready", in_ready, 1);
      check("t5_rst_valid", out_valid, 0);
      send_term(32'd5, 0, 0);
      send_term(32'd7, 1, 0);
      get_result("t5", 12, 2, 0, 0);

      // 6: random transactions with random input gaps and output stalls
      for (int k = 0; k < 200; k++) begin
         n           = $urandom_range(1, MAX_TERMS);
         force_close = (n == MAX_TERMS) && ($urandom_range(0, 1) == 1);
         sum         = 0;
         for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
               0:       t = WIDTH'($urandom_range(0, 255));
               1:       t = 32'hFFFF_FFFF - WIDTH'($urandom_range(0, 15));
               default: t = $urandom;
            endcase
            sum = sum + 64'(t);
            send_term(t, (i == n - 1) && !force_close, $urandom_range(0, 2));
         end
         get_result("rnd", sum, n, force_close, $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
